// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Moore-FSM control for a multicycle ARM-subset datapath. A single memory
//   port serves both fetch and data accesses, and a single ALU serves both
//   PC+4 and execute. The unit owns the NZCV flags register and predicates
//   every instruction on its condition field. A memory state that waits too
//   long for MemReady sends the unit to FAULT, which only reset leaves.
//
// Ports
//   i_clk, i_reset        clock; synchronous active-high reset
//   i_start               leaves IDLE (ignored elsewhere)
//   i_Cond/i_Op/i_Funct   instruction fields Instr[31:28]/[27:26]/[25:20]
//   i_Rd                  destination register Instr[15:12]
//   i_ALUFlags            NZCV straight from the ALU
//   i_MemReady            memory completes the current access this cycle
//   o_IRWrite..o_AdrSrc   datapath strobes and selects
//   o_ALUSrcA/B, o_ResultSrc, o_ImmSrc, o_RegSrc, o_ALUControl  mux selects
//   o_Flags               architectural NZCV register
//   o_Busy / o_Fault      sequencing in progress / memory timeout fault
module multicycle_control_unit #(
    parameter int ALUCTRL_W = 3,
    parameter int MAX_WAIT  = 255
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [3:0]           i_Cond,
    input  logic [1:0]           i_Op,
    input  logic [5:0]           i_Funct,
    input  logic [3:0]           i_Rd,
    input  logic [3:0]           i_ALUFlags,
    input  logic                 i_MemReady,
    output logic                 o_IRWrite,
    output logic                 o_PCWrite,
    output logic                 o_RegWrite,
    output logic                 o_MemWrite,
    output logic                 o_MemRead,
    output logic                 o_AdrSrc,
    output logic                 o_ALUSrcA,
    output logic [1:0]           o_ALUSrcB,
    output logic [1:0]           o_ResultSrc,
    output logic [1:0]           o_ImmSrc,
    output logic [1:0]           o_RegSrc,
    output logic [ALUCTRL_W-1:0] o_ALUControl,
    output logic [3:0]           o_Flags,
    output logic                 o_Busy,
    output logic                 o_Fault
);

    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    // A waiting cycle seen with the counter here is the MAX_WAIT-th one.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_FAULT
    } state_t;

    state_t            r_state, w_next;
    logic [WAIT_W-1:0] r_wait;
    logic [3:0]        r_flags;
    logic [3:0]        r_exflags;   // ALU flags captured in the EXEC cycle
    logic              r_condex;

    logic       w_condex;
    logic       w_cmd_ok, w_is_cmp, w_nz_only;
    logic [1:0] w_alu_op;
    logic       w_mem_state, w_wait_exp, w_flag_upd;

    // ---------------- condition check against the flags register
    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = r_flags;
        w_condex = 1'b0;
        case (i_Cond)
            4'b0000: w_condex = z;
            4'b0001: w_condex = !z;
            4'b0010: w_condex = c;
            4'b0011: w_condex = !c;
            4'b0100: w_condex = n;
            4'b0101: w_condex = !n;
            4'b0110: w_condex = v;
            4'b0111: w_condex = !v;
            4'b1000: w_condex = c && !z;
            4'b1001: w_condex = !c || z;
            4'b1010: w_condex = (n == v);
            4'b1011: w_condex = (n != v);
            4'b1100: w_condex = !z && (n == v);
            4'b1101: w_condex = z || (n != v);
            4'b1110: w_condex = 1'b1;
            default: w_condex = 1'b0;
        endcase
    end

    // ---------------- data-processing cmd decode
    always_comb begin
        w_cmd_ok  = 1'b1;
        w_is_cmp  = 1'b0;
        w_nz_only = 1'b0;
        w_alu_op  = 2'd0;
        case (i_Funct[4:1])
            4'b0100: w_alu_op = 2'd0;
            4'b0010: w_alu_op = 2'd1;
            4'b0000: begin w_alu_op = 2'd2; w_nz_only = 1'b1; end
            4'b1100: begin w_alu_op = 2'd3; w_nz_only = 1'b1; end
            4'b1010: begin w_alu_op = 2'd1; w_is_cmp  = 1'b1; end
            default: w_cmd_ok = 1'b0;
        endcase
    end

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                         (r_state == S_MEMWR);
    assign w_wait_exp  = !i_MemReady && (r_wait == WAIT_LAST);
    assign w_flag_upd  = (r_state == S_ALUWB) && r_condex && w_cmd_ok &&
                         (i_Funct[0] || w_is_cmp);

    // ---------------- state register and datapath-side registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_wait    <= '0;
            r_flags   <= 4'b0000;
            r_exflags <= 4'b0000;
            r_condex  <= 1'b0;
        end else begin
            r_state <= w_next;
            // Any state change clears the counter, so each entry into a
            // memory state starts a fresh wait window.
            if (w_next != r_state)
                r_wait <= '0;
            else if (w_mem_state && !i_MemReady)
                r_wait <= r_wait + 1'b1;
            if (r_state == S_DECODE)
                r_condex <= w_condex;
            if (r_state == S_EXECR || r_state == S_EXECI)
                r_exflags <= i_ALUFlags;
            if (w_flag_upd) begin
                r_flags[3:2] <= r_exflags[3:2];
                if (!w_nz_only)
                    r_flags[1:0] <= r_exflags[1:0];
            end
        end
    end

    // ---------------- next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_next = S_FETCH;
            S_FETCH:  if (i_MemReady) w_next = S_DECODE;
                      else if (w_wait_exp) w_next = S_FAULT;
            S_DECODE: begin
                if (!w_condex)
                    w_next = S_FETCH;
                else begin
                    case (i_Op)
                        2'b00:   w_next = i_Funct[5] ? S_EXECI : S_EXECR;
                        2'b01:   w_next = S_MEMADR;
                        2'b10:   w_next = S_BRANCH;
                        default: w_next = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: w_next = i_Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (i_MemReady) w_next = S_MEMWB;
                      else if (w_wait_exp) w_next = S_FAULT;
            S_MEMWR:  if (i_MemReady) w_next = S_FETCH;
                      else if (w_wait_exp) w_next = S_FAULT;
            S_MEMWB:  w_next = S_FETCH;
            S_EXECR, S_EXECI: w_next = w_cmd_ok ? S_ALUWB : S_FETCH;
            S_ALUWB:  w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_FAULT:  w_next = S_FAULT;
            default:  w_next = S_IDLE;
        endcase
    end

    // ---------------- outputs (state only, except the FETCH write strobes)
    always_comb begin
        o_IRWrite    = 1'b0;
        o_PCWrite    = 1'b0;
        o_RegWrite   = 1'b0;
        o_MemWrite   = 1'b0;
        o_MemRead    = 1'b0;
        o_AdrSrc     = 1'b0;
        o_ALUSrcA    = 1'b0;
        o_ALUSrcB    = 2'b00;
        o_ResultSrc  = 2'b00;
        o_ImmSrc     = 2'b00;
        o_RegSrc     = 2'b00;
        o_ALUControl = '0;
        case (r_state)
            S_FETCH: begin
                o_MemRead   = 1'b1;
                o_ALUSrcA   = 1'b1;
                o_ALUSrcB   = 2'b10;
                o_ResultSrc = 2'b10;
                o_IRWrite   = i_MemReady;
                o_PCWrite   = i_MemReady;
            end
            S_DECODE: begin
                o_ALUSrcA = 1'b1;
                o_ALUSrcB = 2'b10;
            end
            S_EXECR, S_EXECI: begin
                o_ALUSrcB    = (r_state == S_EXECI) ? 2'b01 : 2'b00;
                o_ALUControl = ALUCTRL_W'(w_alu_op);
            end
            S_ALUWB: begin
                o_RegWrite = r_condex && !w_is_cmp && (i_Rd != 4'd15);
                o_PCWrite  = r_condex && !w_is_cmp && (i_Rd == 4'd15);
            end
            S_MEMADR: begin
                o_ALUSrcB = 2'b01;
                o_ImmSrc  = 2'b01;
            end
            S_MEMRD: begin
                o_AdrSrc  = 1'b1;
                o_MemRead = 1'b1;
            end
            S_MEMWR: begin
                o_AdrSrc   = 1'b1;
                o_RegSrc   = 2'b10;
                o_MemWrite = 1'b1;
            end
            S_MEMWB: begin
                o_ResultSrc = 2'b01;
                o_RegWrite  = r_condex && (i_Rd != 4'd15);
                o_PCWrite   = r_condex && (i_Rd == 4'd15);
            end
            S_BRANCH: begin
                o_ALUSrcA   = 1'b1;
                o_ALUSrcB   = 2'b01;
                o_ImmSrc    = 2'b10;
                o_ResultSrc = 2'b10;
                o_PCWrite   = r_condex;
            end
            default: ;
        endcase
    end

    assign o_Flags = r_flags;
    assign o_Busy  = (r_state != S_IDLE) && (r_state != S_FAULT);
    assign o_Fault = (r_state == S_FAULT);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit. An instruction-level model expands each
// instruction into its expected per-cycle strobe pattern from the ISA rules,
// then the DUT is stepped through it and compared every cycle.
module tb_multicycle_control_unit;

    localparam int MW = 4;

    logic       clk = 1'b0;
    logic       i_reset, i_start, i_MemReady;
    logic [3:0] i_Cond, i_Rd, i_ALUFlags;
    logic [1:0] i_Op;
    logic [5:0] i_Funct;
    logic       o_IRWrite, o_PCWrite, o_RegWrite, o_MemWrite, o_MemRead, o_AdrSrc;
    logic       o_ALUSrcA, o_Busy, o_Fault;
    logic [1:0] o_ALUSrcB, o_ResultSrc, o_ImmSrc, o_RegSrc;
    logic [2:0] o_ALUControl;
    logic [3:0] o_Flags;

    always #5 clk = ~clk;

    multicycle_control_unit #(.ALUCTRL_W(3), .MAX_WAIT(MW)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_Cond(i_Cond),
        .i_Op(i_Op), .i_Funct(i_Funct), .i_Rd(i_Rd), .i_ALUFlags(i_ALUFlags),
        .i_MemReady(i_MemReady), .o_IRWrite(o_IRWrite), .o_PCWrite(o_PCWrite),
        .o_RegWrite(o_RegWrite), .o_MemWrite(o_MemWrite), .o_MemRead(o_MemRead),
        .o_AdrSrc(o_AdrSrc), .o_ALUSrcA(o_ALUSrcA), .o_ALUSrcB(o_ALUSrcB),
        .o_ResultSrc(o_ResultSrc), .o_ImmSrc(o_ImmSrc), .o_RegSrc(o_RegSrc),
        .o_ALUControl(o_ALUControl), .o_Flags(o_Flags), .o_Busy(o_Busy),
        .o_Fault(o_Fault)
    );

    typedef struct packed {
        logic       irw, pcw, rw, mw, mrd, adr, srca;
        logic [1:0] srcb, res, imm, rsrc;
        logic [2:0] aluc;
        logic       busy, fault;
    } outs_t;

    typedef struct {
        outs_t      exp;
        logic       mready;
        logic       start;
        logic [3:0] alufl;
        logic       upd;
        logic [3:0] newfl;
    } step_t;

    outs_t act;
    assign act = {o_IRWrite, o_PCWrite, o_RegWrite, o_MemWrite, o_MemRead,
                  o_AdrSrc, o_ALUSrcA, o_ALUSrcB, o_ResultSrc, o_ImmSrc,
                  o_RegSrc, o_ALUControl, o_Busy, o_Fault};

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [3:0] m_flags = 4'b0000;

    localparam logic [3:0] AL = 4'b1110;

    function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic outs_t busy_o();
        outs_t o;
        o = '0;
        o.busy = 1'b1;
        return o;
    endfunction

    function automatic step_t mk(input outs_t o, input logic mr);
        step_t s;
        s.exp = o; s.mready = mr; s.start = 1'($urandom);
        s.alufl = 4'($urandom); s.upd = 1'b0; s.newfl = 4'b0000;
        return s;
    endfunction

    // Expand one instruction into expected cycles and step the DUT through
    // at most stop_after of them. fw/dw = MemReady-low cycles in fetch/data.
    task automatic run_instr(input string tag, input logic [3:0] cond,
                             input logic [1:0] op, input logic [5:0] funct,
                             input logic [3:0] rd, input int fw, input int dw,
                             input logic [3:0] exfl, input int stop_after);
        step_t q[$];
        step_t s;
        outs_t o;
        logic ok, cmp, nz;
        logic [2:0] ac;
        int nw;
        o = busy_o(); o.mrd = 1; o.srca = 1; o.srcb = 2'b10; o.res = 2'b10;
        for (int i = 0; i < fw; i++) q.push_back(mk(o, 1'b0));
        o.irw = 1; o.pcw = 1;
        q.push_back(mk(o, 1'b1));
        o = busy_o(); o.srca = 1; o.srcb = 2'b10;
        q.push_back(mk(o, 1'($urandom)));
        if (cond_true(cond, m_flags) && op != 2'b11) begin
            case (op)
                2'b00: begin
                    ok = 1; cmp = 0; nz = 0; ac = 3'd0;
                    case (funct[4:1])
                        4'b0100: ac = 3'd0;
                        4'b0010: ac = 3'd1;
                        4'b0000: begin ac = 3'd2; nz = 1; end
                        4'b1100: begin ac = 3'd3; nz = 1; end
                        4'b1010: begin ac = 3'd1; cmp = 1; end
                        default: ok = 0;
                    endcase
                    o = busy_o(); o.srcb = funct[5] ? 2'b01 : 2'b00; o.aluc = ac;
                    s = mk(o, 1'($urandom)); s.alufl = exfl;
                    q.push_back(s);
                    if (ok) begin
                        o = busy_o();
                        o.rw  = !cmp && rd != 4'd15;
                        o.pcw = !cmp && rd == 4'd15;
                        s = mk(o, 1'($urandom));
                        if (funct[0] || cmp) begin
                            s.upd = 1;
                            s.newfl = nz ? {exfl[3:2], m_flags[1:0]} : exfl;
                        end
                        q.push_back(s);
                    end
                end
                2'b01: begin
                    o = busy_o(); o.srcb = 2'b01; o.imm = 2'b01;
                    q.push_back(mk(o, 1'($urandom)));
                    o = busy_o(); o.adr = 1;
                    if (funct[0]) o.mrd = 1;
                    else begin o.mw = 1; o.rsrc = 2'b10; end
                    nw = (dw >= MW) ? MW : dw;
                    for (int i = 0; i < nw; i++) q.push_back(mk(o, 1'b0));
                    if (dw >= MW) begin
                        o = '0; o.fault = 1;
                        s = mk(o, 1'b0); s.start = 1;
                        q.push_back(s);
                    end else begin
                        q.push_back(mk(o, 1'b1));
                        if (funct[0]) begin
                            o = busy_o(); o.res = 2'b01;
                            o.rw = rd != 4'd15; o.pcw = rd == 4'd15;
                            q.push_back(mk(o, 1'($urandom)));
                        end
                    end
                end
                default: begin
                    o = busy_o(); o.srca = 1; o.srcb = 2'b01; o.imm = 2'b10;
                    o.res = 2'b10; o.pcw = 1;
                    q.push_back(mk(o, 1'($urandom)));
                end
            endcase
        end
        i_Cond = cond; i_Op = op; i_Funct = funct; i_Rd = rd;
        for (int i = 0; i < q.size() && i < stop_after; i++) begin
            i_MemReady = q[i].mready; i_ALUFlags = q[i].alufl; i_start = q[i].start;
            #1;
            n_cmp++;
            if (act !== q[i].exp) begin
                n_bad++;
                $display("FAIL %s step %0d outputs: got %h, want %h", tag, i, act, q[i].exp);
            end
            n_cmp++;
            if (o_Flags !== m_flags) begin
                n_bad++;
                $display("FAIL %s step %0d Flags: got %b, want %b", tag, i, o_Flags, m_flags);
            end
            if (q[i].upd) m_flags = q[i].newfl;
            @(posedge clk); #1;
        end
        i_start = 0;
    endtask

    task automatic go_start();
        i_start = 1;
        @(posedge clk); #1;
        i_start = 0;
    endtask

    task automatic test_reset();
        i_reset = 1; i_start = 1; i_MemReady = 1; i_ALUFlags = 4'hF;
        i_Cond = AL; i_Op = 0; i_Funct = 0; i_Rd = 0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (act !== '0 || o_Flags !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_state: got %h flags %b, want 0 flags 0000", act, o_Flags);
        end
        i_reset = 0; i_start = 0;
        @(posedge clk); #1;
        n_cmp++;
        if (act !== '0) begin
            n_bad++;
            $display("FAIL idle_hold: got %h, want 0", act);
        end
        m_flags = 4'b0000;
    endtask

    task automatic test_dp();
        go_start();
        run_instr("adds", AL, 2'b00, 6'b001001, 4'd1, 0, 0, 4'b0100, 99);
        n_cmp++;
        if (o_Flags !== 4'b0100) begin
            n_bad++;
            $display("FAIL adds_flags: got %b, want 0100", o_Flags);
        end
    endtask

    task automatic test_branch();
        run_instr("beq", 4'b0000, 2'b10, 6'($urandom), 4'($urandom), 0, 0, 4'h0, 99);
        run_instr("bne", 4'b0001, 2'b10, 6'($urandom), 4'($urandom), 0, 0, 4'h0, 99);
        run_instr("never", 4'b1111, 2'b00, 6'b001001, 4'd2, 1, 0, 4'h0, 99);
    endtask

    task automatic test_ldr();
        run_instr("ldr_wait", AL, 2'b01, 6'b000001, 4'd1, 0, 3, 4'h0, 99);
        run_instr("ldr_pc", AL, 2'b01, 6'b000001, 4'd15, 0, 0, 4'h0, 99);
        run_instr("str", AL, 2'b01, 6'b000000, 4'd4, 2, 1, 4'h0, 99);
    endtask

    task automatic test_cmp_unsup();
        run_instr("cmp", AL, 2'b00, 6'b010100, 4'd3, 0, 0, 4'b0110, 99);
        run_instr("unsup", AL, 2'b00, 6'b000011, 4'd5, 0, 0, 4'b1001, 99);
        run_instr("ands_nz", AL, 2'b00, 6'b100001, 4'd6, 0, 0, 4'b1001, 99);
        run_instr("subs", AL, 2'b00, 6'b000101, 4'd15, 0, 0, 4'b0110, 99);
    endtask

    task automatic test_reset_mid_ldr();
        run_instr("ldr_rst", AL, 2'b01, 6'b000001, 4'd2, 0, 3, 4'h0, 5);
        i_MemReady = 0;
        #1;
        n_cmp++;
        if (o_MemRead !== 1'b1) begin
            n_bad++;
            $display("FAIL ldr_rst_memread: got %b, want 1", o_MemRead);
        end
        i_reset = 1;
        @(posedge clk); #1;
        n_cmp++;
        if (act !== '0 || o_Flags !== 4'b0000) begin
            n_bad++;
            $display("FAIL ldr_rst_idle: got %h flags %b, want 0 flags 0000", act, o_Flags);
        end
        i_reset = 0;
        m_flags = 4'b0000;
    endtask

    task automatic test_fault();
        outs_t f;
        f = '0; f.fault = 1;
        go_start();
        run_instr("str_timeout", AL, 2'b01, 6'b000000, 4'd1, 0, MW, 4'h0, 99);
        i_start = 1; i_MemReady = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (act !== f) begin
                n_bad++;
                $display("FAIL fault_hold %0d: got %h, want %h", i, act, f);
            end
            @(posedge clk); #1;
        end
        i_reset = 1; i_start = 0;
        @(posedge clk); #1;
        n_cmp++;
        if (act !== '0) begin
            n_bad++;
            $display("FAIL fault_reset: got %h, want 0", act);
        end
        i_reset = 0;
        m_flags = 4'b0000;
    endtask

    task automatic test_random_back_to_back();
        logic [3:0] c, rd;
        go_start();
        for (int k = 0; k < 60; k++) begin
            c  = ($urandom_range(0, 1) == 0) ? AL : 4'($urandom);
            rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
            run_instr("rand", c, 2'($urandom), 6'($urandom), rd,
                      $urandom_range(0, 2), $urandom_range(0, 2), 4'($urandom), 99);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_dp();
        test_branch();
        test_ldr();
        test_cmp_unsup();
        test_reset_mid_ldr();
        test_fault();
        test_random_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Parametrised multicycle successor to the single-cycle ARM-subset control unit. It sequences one instruction over several cycles through a Moore FSM, so one memory port serves both fetch and data and one ALU serves both PC+4 and execute. It owns the NZCV flags register and predicates every instruction on its condition field. It waits on a memory-ready handshake and faults on memory timeout. It sits inside the CPU top, between the instruction register fields and a multicycle datapath.

## Interface
- ALUCTRL_W, 3: ALUControl width, ≥3; codes are zero-extended.
- MAX_WAIT, 255: cycles a memory state may wait for MemReady before faulting; ≥1.
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high.
- start  in  1  leaves IDLE; sampled only in IDLE.
- Cond  in  4  Instr[31:28].
- Op  in  2  Instr[27:26]: 00 data-processing, 01 memory, 10 branch.
- Funct  in  6  Instr[25:20]: [5] I, [4:1] cmd, [0] S (for Op=01: [0] L).
- Rd  in  4  Instr[15:12].
- ALUFlags  in  4  NZCV from the ALU, combinational.
- MemReady  in  1  memory completes the current access this cycle.
- IRWrite, PCWrite, RegWrite, MemWrite, MemRead, AdrSrc  out  1 each.
- ALUSrcA  out  1  0 = Rn, 1 = PC.
- ALUSrcB  out  2  00 = reg, 01 = ExtImm, 10 = const 4.
- ResultSrc  out  2  00 = ALUOut reg, 01 = Data reg, 10 = ALU direct.
- ImmSrc, RegSrc  out  2 each  same meaning as in the single-cycle decoder.
- ALUControl  out  ALUCTRL_W  ADD=0, SUB=1, AND=2, ORR=3.
- Flags  out  4  current NZCV register.
- Busy  out  1  high in every state except IDLE and FAULT.
- Fault  out  1  high only in FAULT.

## Operation
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, FAULT.
- IDLE: all strobes low. start=1 → FETCH.
- FETCH: MemRead=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10.
  - IRWrite and PCWrite assert only in the cycle MemReady=1; that cycle also moves to DECODE.
  - Otherwise stay in FETCH.
- DECODE: ALUSrcA=1, ALUSrcB=10 (PC+8 for branch). Evaluate Cond against the Flags register, not ALUFlags; latch the result as CondEx.
  - CondEx=0 → FETCH (instruction is a NOP).
  - Op=00 with I=0 → EXECR; with I=1 → EXECI.
  - Op=01 → MEMADR.
  - Op=10 → BRANCH.
  - Op=11 → FETCH.
- Condition codes: standard ARM EQ..LE; 1110 = always; 1111 = never.
- cmd decode: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB, no register write, flags always updated).
  - Any other cmd → FETCH from EXECR/EXECI with no writes.
- EXECR / EXECI: ALUSrcB = 00 / 01; ImmSrc=00 → ALUWB.
- ALUWB: ResultSrc=00.
  - Rd≠15 and not CMP → RegWrite=1.
  - Rd=15 and not CMP → PCWrite=1, RegWrite=0.
  - Flags register loads ALUFlags captured in the EXEC cycle when S=1 or CMP. ADD/SUB update NZCV; AND/ORR update NZ only.
  - → FETCH.
- MEMADR: ALUSrcB=01, ImmSrc=01, ALUControl=ADD (U bit not supported). L=1 → MEMRD; L=0 → MEMWR.
- MEMRD: AdrSrc=1, MemRead=1. MemReady → MEMWB.
- MEMWR: AdrSrc=1, RegSrc[1]=1, MemWrite=1 held until MemReady. MemReady → FETCH.
- MEMWB: ResultSrc=01; RegWrite=1, or PCWrite=1 if Rd=15 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=01, ImmSrc=10, ResultSrc=10, PCWrite=1 → FETCH.
- Wait counter: clears on entry to FETCH/MEMRD/MEMWR and counts each cycle MemReady=0. Reaching MAX_WAIT → FAULT. FAULT holds until reset.

## Timing
- Moore outputs, registered state; strobes are valid in the cycle they name.
- Cycles with MemReady tied high:
  - B: 3.
  - DP and STR: 4.
  - LDR: 5.
  - Condition-failed instruction: 2.
- Each MemReady=0 cycle in a memory state adds one cycle.
- Reset: state=IDLE, Flags=0000, wait counter=0, every output 0. Reset wins over any transition, including in FAULT.
- The Flags update in ALUWB is visible to the next instruction's DECODE.

## Test plan
- Reset mid-LDR, while in MEMRD → next cycle IDLE, all strobes 0, Flags=0000, Busy=0.
- start, ADDS Rd=1 giving ALU Z=1, MemReady=1 → FETCH, DECODE, EXECR, ALUWB; RegWrite=1 in cycle 4; Flags=0100 afterwards.
- Following BEQ → 3 cycles, PCWrite in BRANCH. Then BNE → returns to FETCH after DECODE, PCWrite never asserted beyond fetch.
- LDR with MemReady low 3 cycles in MEMRD → 8 total cycles; MemRead held; RegWrite=1 in MEMWB. With Rd=15 → PCWrite=1, RegWrite=0.
- STR with MAX_WAIT=4 and MemReady stuck 0 → FAULT after 4 wait cycles, Fault=1, Busy=0; start ignored; reset → IDLE.
- CMP with cmd=1010 → RegWrite never 1, Flags updated. Unsupported cmd 0001 → no writes, Flags unchanged, back to FETCH.
